dmem_responder: RTL and testbench

Data-memory responder for the MIPS core: the memory-side end of the load/store path. It accepts one load or store request at a time from the core's memory stage over a req/ready/ack handshake and serves it from an internal word array after a programmable number of wait states. Bad addresses are flagged with an error response. The core holds its memory stage until `o_ack`, so the array can later be swapped for slower storage without pipeline changes.

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store handshake between the core's memory stage (master) and the data-memory responder (slave).
interface dmem_if;
   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [3:0]  i_be;
   logic        o_ready;
   logic        o_ack;
   logic [31:0] o_rdata;
   logic        o_err;

   modport master (
      output i_req, i_we, i_addr, i_wdata, i_be,
      input  o_ready, o_ack, o_rdata, o_err
   );

   modport slave (
      input  i_req, i_we, i_addr, i_wdata, i_be,
      output o_ready, o_ack, o_rdata, o_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, served after WAIT_CYCLES wait states.
// Define DMEM_BYTE_LANES_EN to make stores honour i_be; otherwise stores write the full word.
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2  = 6,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic   i_clk,
   input  logic   i_rst,
   dmem_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [31:0] mem [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  bad_q, bad_d;
   logic                  ready_q, ready_d;
   logic                  ack_q, ack_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic                  addr_bad;
   logic                  sel_we;
   logic                  sel_bad;
   logic [DEPTH_LOG2-1:0] sel_idx;
   logic                  mem_we;

   assign accept   = (state_q == ST_IDLE) && bus.i_req;
   assign addr_bad = (bus.i_addr[1:0] != 2'b00) || (|bus.i_addr[31:DEPTH_LOG2+2]);

   // With zero wait states RESP is entered straight from IDLE, so use the live request.
   assign sel_we  = accept ? bus.i_we : we_q;
   assign sel_bad = accept ? addr_bad : bad_q;
   assign sel_idx = accept ? bus.i_addr[DEPTH_LOG2+1:2] : idx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      bad_d   = bad_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_req) begin
               we_d    = bus.i_we;
               idx_d   = bus.i_addr[DEPTH_LOG2+1:2];
               wdata_d = bus.i_wdata;
               bad_d   = addr_bad;
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_RESP) && (state_q != ST_RESP) && !sel_we)
         rdata_d = sel_bad ? 32'd0 : mem[sel_idx];

      ready_d = (state_d == ST_IDLE);
      ack_d   = (state_d == ST_RESP);
      err_d   = (state_d == ST_RESP) && sel_bad;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         bad_q   <= 1'b0;
         ready_q <= 1'b1;
         ack_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         bad_q   <= bad_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store commits on the edge that ends RESP; a reset in flight drops it.
   assign mem_we = (state_q == ST_RESP) && we_q && !bad_q && !i_rst;

`ifdef DMEM_BYTE_LANES_EN
   logic [3:0] be_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        be_q <= 4'd0;
      else if (accept)  be_q <= bus.i_be;
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (be_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
         end
      end
   end
`else
   logic unused_be;
   assign unused_be = ^bus.i_be;

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[idx_q] <= wdata_q;
   end
`endif

   assign bus.o_ready = ready_q;
   assign bus.o_ack   = ack_q;
   assign bus.o_rdata = rdata_q;
   assign bus.o_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance for function/latency, WAIT_CYCLES=0 for throughput.
module tb_dmem_responder;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rd;
      logic        err;
   } vec_t;

`ifdef DMEM_BYTE_LANES_EN
   localparam logic [31:0] EXP_BL = 32'h11BB33DD;
`else
   localparam logic [31:0] EXP_BL = 32'hAABBCCDD;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_if b2();
   dmem_if b0();

   dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut  (.i_clk(clk), .i_rst(rst), .bus(b2));
   dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));

   int total = 0;
   int bad   = 0;

   vec_t tbl  [19];
   vec_t tbl0 [6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // One transaction on the WAIT_CYCLES=2 instance; ack expected 3 cycles after acceptance.
   task automatic txn2(input vec_t v, input int id);
      int lat;
      @(negedge clk);
      chk($sformatf("v%0d_ready_idle", id), 32'(b2.o_ready), 32'd1);
      b2.i_req = 1'b1; b2.i_we = v.we; b2.i_addr = v.addr; b2.i_wdata = v.wdata; b2.i_be = v.be;
      @(posedge clk);
      @(negedge clk);
      b2.i_req = 1'b0;
      lat = 1;
      chk($sformatf("v%0d_ready_busy", id), 32'(b2.o_ready), 32'd0);
      while (!b2.o_ack && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", id), 32'(lat), 32'd3);
      chk($sformatf("v%0d_err", id), 32'(b2.o_err), 32'(v.err));
      chk($sformatf("v%0d_rdata", id), b2.o_rdata, v.rd);
   endtask

   initial begin
      //            we    addr          wdata          be       rd             err
      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF,  1'b0};
      tbl[2]  = '{1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF,  1'b0};
      tbl[3]  = '{1'b0, 32'h0000_0002, 32'h0,        4'hF, 32'h0000_0000, 1'b1};
      tbl[4]  = '{1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0000_0000, 1'b1};
      tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'hCAFEF00D,  1'b0};
      tbl[6]  = '{1'b1, 32'h0000_0100, 32'hBAD0BAD0, 4'hF, 32'hCAFEF00D,  1'b1};
      tbl[7]  = '{1'b1, 32'h0000_0003, 32'hBAD0BAD0, 4'hF, 32'hCAFEF00D,  1'b1};
      tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'hCAFEF00D,  1'b0};
      tbl[9]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'hCAFEF00D,  1'b0};
      tbl[10] = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'hCAFEF00D,  1'b0};
      tbl[11] = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, EXP_BL,        1'b0};
      tbl[12] = '{1'b1, 32'h0000_0008, 32'h0BADCAFE, 4'hF, EXP_BL,        1'b0};
      tbl[13] = '{1'b0, 32'h0000_0008, 32'h0,        4'hF, 32'h0BADCAFE,  1'b0};
      tbl[14] = '{1'b1, 32'h0000_000C, 32'h77777777, 4'hF, 32'h0BADCAFE,  1'b0};
      tbl[15] = '{1'b0, 32'h0000_000C, 32'h0,        4'hF, 32'h77777777,  1'b0};
      tbl[16] = '{1'b1, 32'h0000_00FC, 32'h12345678, 4'hF, 32'h77777777,  1'b0};
      tbl[17] = '{1'b0, 32'h0000_00FC, 32'h0,        4'hF, 32'h12345678,  1'b0};
      tbl[18] = '{1'b1, 32'h0000_0004, 32'h00000000, 4'hF, 32'h12345678,  1'b0};

      tbl0[0] = '{1'b1, 32'h0000_0000, 32'hA0A0A0A0, 4'hF, 32'h0000_0000, 1'b0};
      tbl0[1] = '{1'b1, 32'h0000_0004, 32'hB1B1B1B1, 4'hF, 32'h0000_0000, 1'b0};
      tbl0[2] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'hA0A0A0A0,  1'b0};
      tbl0[3] = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'hB1B1B1B1,  1'b0};
      tbl0[4] = '{1'b1, 32'h0000_0004, 32'hC2C2C2C2, 4'hF, 32'hB1B1B1B1,  1'b0};
      tbl0[5] = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'hC2C2C2C2,  1'b0};

      b2.i_req = 1'b0; b2.i_we = 1'b0; b2.i_addr = 32'd0; b2.i_wdata = 32'd0; b2.i_be = 4'hF;
      b0.i_req = 1'b0; b0.i_we = 1'b0; b0.i_addr = 32'd0; b0.i_wdata = 32'd0; b0.i_be = 4'hF;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      chk("rst_ready", 32'(b2.o_ready), 32'd1);
      chk("rst_ack",   32'(b2.o_ack),   32'd0);
      chk("rst_err",   32'(b2.o_err),   32'd0);
      chk("rst_rdata", b2.o_rdata,      32'd0);

      for (int i = 0; i < 19; i++) txn2(tbl[i], i);

      // Reset during WAIT drops the pending store and issues no ack.
      @(negedge clk);
      b2.i_req = 1'b1; b2.i_we = 1'b1; b2.i_addr = 32'h4; b2.i_wdata = 32'h55555555; b2.i_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      b2.i_req = 1'b0;
      chk("mid_in_wait_ready", 32'(b2.o_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(b2.o_ready), 32'd1);
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_ack", 32'(b2.o_ack), 32'd0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_ack",   32'(b2.o_ack),   32'd0);
         chk("post_rst_ready", 32'(b2.o_ready), 32'd1);
      end
      txn2('{1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0}, 100);

      // Back-to-back on the zero-wait instance with i_req held high throughout.
      @(negedge clk);
      chk("b0_ready_idle", 32'(b0.o_ready), 32'd1);
      b0.i_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b0.i_we = tbl0[i].we; b0.i_addr = tbl0[i].addr; b0.i_wdata = tbl0[i].wdata; b0.i_be = tbl0[i].be;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b0_%0d_ack", i),   32'(b0.o_ack),   32'd1);
         chk($sformatf("b0_%0d_ready", i), 32'(b0.o_ready), 32'd0);
         chk($sformatf("b0_%0d_err", i),   32'(b0.o_err),   32'(tbl0[i].err));
         chk($sformatf("b0_%0d_rdata", i), b0.o_rdata,      tbl0[i].rd);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b0_%0d_gap_ack", i),   32'(b0.o_ack),   32'd0);
         chk($sformatf("b0_%0d_gap_ready", i), 32'(b0.o_ready), 32'd1);
      end
      b0.i_req = 1'b0;
      @(negedge clk);
      chk("b0_idle_ack", 32'(b0.o_ack), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
